// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 max/avg pooling over a row-major pixel stream.
// Even rows leave horizontal pair results in a line buffer; odd rows finish each window.
module pool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_N  = IMG_W / 2;
  localparam int unsigned LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic                         mode_q, mode_d;
  logic signed [DATA_WIDTH-1:0] h_hold_q, h_hold_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic signed [DATA_WIDTH:0]   lb_q [LB_N];

  logic                         accept_c;
  logic                         lb_we_c;
  logic [LB_AW-1:0]             lb_idx_c;
  logic signed [DATA_WIDTH:0]   h_ext_c, x_ext_c, pair_c, lb_rd_c, win_max_c;
  logic signed [DATA_WIDTH+1:0] win_sum_c;
  logic [DATA_WIDTH-1:0]        win_c;
  logic                         unused_bits_c;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept_c   = in_valid && in_ready;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = out_valid_q && out_ready && out_last_q;

  // Pair and window datapath; widths are chosen so neither sum can overflow.
  always_comb begin
    lb_idx_c  = LB_AW'(col_q >> 1);
    h_ext_c   = $signed({h_hold_q[DATA_WIDTH-1], h_hold_q});
    x_ext_c   = $signed({in_data[DATA_WIDTH-1], in_data});
    pair_c    = mode_q ? ((h_ext_c > x_ext_c) ? h_ext_c : x_ext_c) : (h_ext_c + x_ext_c);
    lb_rd_c   = lb_q[lb_idx_c];
    win_max_c = (pair_c > lb_rd_c) ? pair_c : lb_rd_c;
    win_sum_c = $signed({pair_c[DATA_WIDTH], pair_c}) + $signed({lb_rd_c[DATA_WIDTH], lb_rd_c});
    // Dropping the two LSBs of the signed sum is the floor divide by four.
    win_c     = mode_q ? win_max_c[DATA_WIDTH-1:0] : win_sum_c[DATA_WIDTH+1:2];
    unused_bits_c = ^{win_max_c[DATA_WIDTH], win_sum_c[1:0]};
  end

  // Position counters, mode latch, hold register and output register control.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    h_hold_d    = h_hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    lb_we_c     = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept_c) begin
      if (row_q == '0 && col_q == '0) mode_d = mode;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        h_hold_d = $signed(in_data);
      end else if (!row_q[0]) begin
        lb_we_c = 1'b1;
      end else begin
        out_data_d  = win_c;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b1;
      h_hold_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      h_hold_q    <= h_hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer contents need no reset: every entry is rewritten on an even row before use.
  always_ff @(posedge clk) begin
    if (lb_we_c) lb_q[lb_idx_c] <= pair_c;
  end

endmodule

// File: doc/pool2x2_stream.md
Name: pool2x2_stream

Overview:
- Streaming 2x2, stride-2 pooling engine. Successor to the combinational four-input max/avg pooler, parametrised in data width and feature-map size.
- Accepts one feature-map pixel per cycle in row-major order over a valid/ready handshake.
- Buffers horizontal pair results of each even row in an internal line buffer. Emits one pooled pixel per 2x2 window, either max or average.
- Sits between the convolution/activation output stream and the next layer's input buffer.

Parameters:
- DATA_WIDTH, 8, pixel width; signed two's complement.
- IMG_W, 28, feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, feature-map height in rows; must be even and >= 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  1 = max pooling, 0 = average pooling. Sampled on the first accepted pixel of each frame.
- in_data  input  DATA_WIDTH  input pixel, signed.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a pixel this cycle.
- out_data  output  DATA_WIDTH  pooled pixel, signed.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- frame_done  output  1  one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Behaviour:
- Reset: out_valid=0, out_data=0, frame_done=0, col=0, row=0, mode_q=1. Line buffer contents are don't-care.
- Input handshake: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. Back-pressure is full-throughput: accept and emit can both happen in the same cycle.
- Counters:
  - col counts 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
  - row counts 0..IMG_H-1; at IMG_H-1 it wraps to 0.
  - Counters advance only on accepted pixels.
- mode_q:
  - Latched from mode when a pixel is accepted at row=0, col=0.
  - Changes to mode mid-frame have no effect until the next frame.
- Even col: the pixel is held in register h_hold.
- Odd col: a horizontal pair result p is formed from h_hold and the current pixel.
  - Max mode: signed max.
  - Avg mode: signed sum, DATA_WIDTH+1 bits.
- Even row, odd col: p is written to line buffer entry col/2. The buffer has IMG_W/2 entries of DATA_WIDTH+1 bits.
- Odd row, odd col: p is combined with line buffer entry col/2.
  - Max mode: signed max of the two.
  - Avg mode: DATA_WIDTH+2-bit signed sum, arithmetic shift right by 2 (floor toward -inf), truncated to DATA_WIDTH bits. Truncation is lossless.
  - The result loads the output register and out_valid=1 the next cycle.
- Latency: 1 cycle from acceptance of the window's fourth pixel to out_valid.
- Output register:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready unless a new result loads in the same cycle.
- Output count: IMG_W/2 * IMG_H/2 pooled pixels per frame, emitted in row-major order.
- frame_done pulses in the cycle the final pooled pixel of a frame is accepted, i.e. the one produced at row=IMG_H-1, col=IMG_W-1.
- Frames are back-to-back: after the wrap to row=0, col=0, the next frame's first pixel may be accepted with no bubble.
- Mid-operation reset: aborts the frame, drops the pending output and restores all reset values. The next accepted pixel is treated as row 0, col 0.
- Equal values in max mode produce the common value; tie-breaking is invisible.
- No overflow is possible in either mode.

Test Plan:
- IMG_W=4, IMG_H=4, mode=1, pixels 0..15, out_ready=1 -> out_data 5, 7, 13, 15. Each appears 1 cycle after pixels 5, 7, 13, 15; frame_done pulses with 15.
- Same stream, mode=0 -> out_data 2, 4, 10, 12 (e.g. (0+1+4+5)>>2 = 2).
- Signed avg: window -1, -2, -3, -4 (0xFF, 0xFE, 0xFD, 0xFC) -> sum -10, floor -> out_data -3 (0xFD). Signed max of the same window -> -1 (0xFF).
- Back-pressure: hold out_ready=0 after the first result -> out_data stays 5 and in_ready=0 until out_ready rises. No pixel is lost, and the remaining outputs are still 7, 13, 15.
- mode toggled 1->0 at pixel 6 -> frame 1 is still all max. A second back-to-back frame with mode=0 yields averages with no idle cycle between frames.
- rst asserted for one cycle after pixel 9 -> out_valid=0, counters cleared. A fresh 16-pixel frame then produces exactly 4 correct outputs.
